rtc_preset_sequencer: RTL and testbench
=======================================

// Module: rtc_preset_sequencer
// PURPOSE
//  Front-panel time-set controller for the HH:MM:SS:CS real-time clock. Debounces two push-keys,
//  walks the user through HH -> MM -> SS -> CS entry from the 8-bit BCD switch bus and validates and clamps each field.
//  Then issues a single-cycle Load strobe carrying all four binary preset values to the field counters.
//  Gates the clock run-enable while an edit is in progress. Sits between KEY/SW pins and the counter chain.
// PARAMETERS
//  DEB_CYCLES  500000   cycles a key must be stable low before a press is accepted (10 ms @ 50 MHz)
//  DEB_W       19       width of debounce counter; must hold DEB_CYCLES
//  BLINK_DIV   12500000 half-period of edit-field blink, in Clk cycles (used only with RTC_BLINK_EN)
// PORTS
//  Clk         in   1  system clock (CLOCK_50)
//  Clrn        in   1  asynchronous active-low reset
//  Key_set_n   in   1  raw active-low key: enter edit / abort edit
//  Key_next_n  in   1  raw active-low key: capture current field, advance
//  Sw_bcd      in   8  two BCD digits {tens[7:4], units[3:0]}
//  Run_en_in   in   1  user run switch
//  Run_en      out  1  enable to counters = Run_en_in & (state==IDLE)
//  Load        out  1  one-cycle preset strobe
//  Ld_hh       out  5  binary hours, 0..23, valid while Load=1 (held afterwards)
//  Ld_mm       out  6  binary minutes, 0..59
//  Ld_ss       out  6  binary seconds, 0..59
//  Ld_cs       out  7  binary centiseconds, 0..99
//  Editing     out  1  1 in any EDIT_* state
//  Field_sel   out  2  0=HH 1=MM 2=SS 3=CS; 0 outside edit
//  Err         out  1  one-cycle pulse: rejected capture (BCD digit > 9)
// BEHAVIOUR
//  Reset (Clrn=0, async): state IDLE; Load=0, Err=0, Editing=0, Field_sel=0; Ld_*=0; shadow regs=0; debouncers cleared.
//  Key input: 2-flop synchronizer, then counter; press pulse (1 cycle) when synced level has been low
//   for DEB_CYCLES consecutive cycles; one pulse per press; release needs DEB_CYCLES stable high to re-arm.
//   Latency key-low -> pulse = 2 + DEB_CYCLES cycles.
//  States: IDLE, EDIT_HH, EDIT_MM, EDIT_SS, EDIT_CS, COMMIT.
//   IDLE    --set--> EDIT_HH (Run_en drops next cycle; counters freeze)
//   EDIT_x  --next, valid--> shadow_x <= clamp(bin), go to next field; EDIT_CS -> COMMIT
//   EDIT_x  --next, invalid--> Err=1 for 1 cycle, shadow unchanged, stay
//   EDIT_x  --set--> IDLE (abort), no Load; shadows retain captured values
//   COMMIT  -> IDLE unconditionally; Load=1 this cycle, Ld_* = shadows (registered outputs)
//  Set and next pulses in same cycle: set wins (enter or abort); next ignored.
//  Keys ignored during COMMIT.
//  Conversion: bin = tens*10 + units, 7-bit; valid iff tens<=9 and units<=9.
//  Clamp: HH>23->23, MM>59->59, SS>59->59; CS max 99 by construction. Truncate to field width after clamp.
//  Ld_* change only in COMMIT; stable at all other times.
//  Run_en combinational from state register and Run_en_in; never glitches inside a state.
//  Reset mid-edit: returns to IDLE, no Load, shadows cleared.
// CONFIGURATION
//  RTC_BLINK_EN defined: extra output Blink_mask[3:0] (bit3=HH..bit0=CS). Free-running counter toggles
//   phase every BLINK_DIV cycles while Editing; mask bit of the current field = phase, others 0. Counter and
//   phase cleared on reset and on leaving edit; Blink_mask=0 when not Editing.
//  RTC_BLINK_EN undefined: no Blink_mask port, no blink counter; all else identical.
// TESTING  (bench overrides DEB_CYCLES=4, BLINK_DIV=8)
//  1 full set: set; next with Sw_bcd=8'h12, 8'h34, 8'h56, 8'h78 -> one Load pulse with Ld_hh=12,
//    Ld_mm=34, Ld_ss=56, Ld_cs=78; Run_en low throughout edit, high again cycle after COMMIT.
//  2 clamp/error: HH entry 8'h31 -> Ld_hh=23; MM entry 8'h7A -> Err pulse, stays EDIT_MM, Field_sel=1;
//    then 8'h99 -> Ld_mm=59.
//  3 debounce: key low 3 cycles then high, repeated bounces -> no pulse; held low 6+ cycles -> exactly one pulse.
//  4 abort/simultaneous: in EDIT_SS assert set and next same cycle -> IDLE, no Load, Err=0, Run_en=Run_en_in.
//  5 async reset in EDIT_MM -> all outputs 0 immediately; next set press starts at EDIT_HH, shadows 0.
//  6 RTC_BLINK_EN: in EDIT_SS Blink_mask toggles 4'b0010/4'b0000 every 8 cycles; 0 in IDLE.

Source files
------------

// File: rtl/rtc_preset_sequencer.sv
// rtl/rtc_preset_sequencer.sv - front-panel HH:MM:SS:CS time-set sequencer (optional blink via RTC_BLINK_EN)

// Key debouncer: two-flop synchronizer followed by a stability counter.
// A one-cycle press pulse is emitted when the synced level has been low for
// DEB_CYCLES consecutive cycles; a release must be equally stable to re-arm.
module rtc_key_debounce #(
   parameter int DEB_CYCLES = 500000,
   parameter int DEB_W      = 19
) (
   input  logic Clk,
   input  logic Clrn,
   input  logic key_n_i,
   output logic press_o
);

   logic             sync1_q, sync2_q;
   logic             stable_q, stable_d;
   logic             press_q, press_d;
   logic [DEB_W-1:0] cnt_q, cnt_d;

   // Metastability guard: keys idle high, so the chain resets to released.
   always_ff @(posedge Clk or negedge Clrn) begin
      if (!Clrn) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
      end else begin
         sync1_q <= key_n_i;
         sync2_q <= sync1_q;
      end
   end

   // Count cycles the synced level disagrees with the accepted level; flip after DEB_CYCLES.
   always_comb begin
      cnt_d    = '0;
      stable_d = stable_q;
      press_d  = 1'b0;
      if (sync2_q != stable_q) begin
         if (cnt_q == DEB_W'(DEB_CYCLES - 1)) begin
            stable_d = sync2_q;
            press_d  = ~sync2_q;
         end else begin
            cnt_d = cnt_q + DEB_W'(1);
         end
      end
   end

   // Debounce state registers.
   always_ff @(posedge Clk or negedge Clrn) begin
      if (!Clrn) begin
         cnt_q    <= '0;
         stable_q <= 1'b1;
         press_q  <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         stable_q <= stable_d;
         press_q  <= press_d;
      end
   end

   assign press_o = press_q;

endmodule

module rtc_preset_sequencer #(
   parameter int DEB_CYCLES = 500000,
   parameter int DEB_W      = 19,
   parameter int BLINK_DIV  = 12500000
) (
   input  logic       Clk,
   input  logic       Clrn,
   input  logic       Key_set_n,
   input  logic       Key_next_n,
   input  logic [7:0] Sw_bcd,
   input  logic       Run_en_in,
   output logic       Run_en,
   output logic       Load,
   output logic [4:0] Ld_hh,
   output logic [5:0] Ld_mm,
   output logic [5:0] Ld_ss,
   output logic [6:0] Ld_cs,
   output logic       Editing,
   output logic [1:0] Field_sel,
   output logic       Err
`ifdef RTC_BLINK_EN
   ,
   output logic [3:0] Blink_mask
`endif
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      EDIT_HH = 3'd1,
      EDIT_MM = 3'd2,
      EDIT_SS = 3'd3,
      EDIT_CS = 3'd4,
      COMMIT  = 3'd5
   } state_t;

   state_t     state_q, state_d;
   logic       set_p, next_p;
   logic [3:0] tens, units;
   logic       bcd_ok;
   logic [6:0] bin;
   logic [4:0] hh_clamp;
   logic [5:0] mm_clamp, ss_clamp;
   logic [4:0] sh_hh_q, sh_hh_d;
   logic [5:0] sh_mm_q, sh_mm_d, sh_ss_q, sh_ss_d;
   logic [6:0] sh_cs_q, sh_cs_d;
   logic [4:0] ld_hh_q, ld_hh_d;
   logic [5:0] ld_mm_q, ld_mm_d, ld_ss_q, ld_ss_d;
   logic [6:0] ld_cs_q, ld_cs_d;
   logic       load_q, load_d;
   logic       err_q, err_d;
   logic       editing;
   logic [1:0] field_sel;

   rtc_key_debounce #(.DEB_CYCLES(DEB_CYCLES), .DEB_W(DEB_W)) u_deb_set (
      .Clk     (Clk),
      .Clrn    (Clrn),
      .key_n_i (Key_set_n),
      .press_o (set_p)
   );

   rtc_key_debounce #(.DEB_CYCLES(DEB_CYCLES), .DEB_W(DEB_W)) u_deb_next (
      .Clk     (Clk),
      .Clrn    (Clrn),
      .key_n_i (Key_next_n),
      .press_o (next_p)
   );

   // BCD switch decode: validity, binary value and per-field clamps.
   always_comb begin
      tens     = Sw_bcd[7:4];
      units    = Sw_bcd[3:0];
      bcd_ok   = (tens <= 4'd9) && (units <= 4'd9);
      bin      = {3'b000, tens} * 7'd10 + {3'b000, units};
      hh_clamp = (bin > 7'd23) ? 5'd23 : bin[4:0];
      mm_clamp = (bin > 7'd59) ? 6'd59 : bin[5:0];
      ss_clamp = (bin > 7'd59) ? 6'd59 : bin[5:0];
   end

   // Edit-status decode from the state register only, so it is glitch-free per state.
   always_comb begin
      editing   = 1'b0;
      field_sel = 2'd0;
      case (state_q)
         EDIT_HH: begin editing = 1'b1; field_sel = 2'd0; end
         EDIT_MM: begin editing = 1'b1; field_sel = 2'd1; end
         EDIT_SS: begin editing = 1'b1; field_sel = 2'd2; end
         EDIT_CS: begin editing = 1'b1; field_sel = 2'd3; end
         default: begin editing = 1'b0; field_sel = 2'd0; end
      endcase
   end

   // Next-state logic: set beats next; invalid capture pulses Err and stays put.
   always_comb begin
      state_d = state_q;
      sh_hh_d = sh_hh_q;
      sh_mm_d = sh_mm_q;
      sh_ss_d = sh_ss_q;
      sh_cs_d = sh_cs_q;
      ld_hh_d = ld_hh_q;
      ld_mm_d = ld_mm_q;
      ld_ss_d = ld_ss_q;
      ld_cs_d = ld_cs_q;
      load_d  = 1'b0;
      err_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (set_p) state_d = EDIT_HH;
         end
         EDIT_HH, EDIT_MM, EDIT_SS, EDIT_CS: begin
            if (set_p) begin
               state_d = IDLE;
            end else if (next_p) begin
               if (!bcd_ok) begin
                  err_d = 1'b1;
               end else begin
                  case (state_q)
                     EDIT_HH: begin sh_hh_d = hh_clamp; state_d = EDIT_MM; end
                     EDIT_MM: begin sh_mm_d = mm_clamp; state_d = EDIT_SS; end
                     EDIT_SS: begin sh_ss_d = ss_clamp; state_d = EDIT_CS; end
                     default: begin sh_cs_d = bin;      state_d = COMMIT;  end
                  endcase
               end
            end
         end
         COMMIT: begin
            state_d = IDLE;
            load_d  = 1'b1;
            ld_hh_d = sh_hh_q;
            ld_mm_d = sh_mm_q;
            ld_ss_d = sh_ss_q;
            ld_cs_d = sh_cs_q;
         end
         default: state_d = IDLE;
      endcase
   end

   // State, shadow and registered-output flops.
   always_ff @(posedge Clk or negedge Clrn) begin
      if (!Clrn) begin
         state_q <= IDLE;
         sh_hh_q <= '0;
         sh_mm_q <= '0;
         sh_ss_q <= '0;
         sh_cs_q <= '0;
         ld_hh_q <= '0;
         ld_mm_q <= '0;
         ld_ss_q <= '0;
         ld_cs_q <= '0;
         load_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         sh_hh_q <= sh_hh_d;
         sh_mm_q <= sh_mm_d;
         sh_ss_q <= sh_ss_d;
         sh_cs_q <= sh_cs_d;
         ld_hh_q <= ld_hh_d;
         ld_mm_q <= ld_mm_d;
         ld_ss_q <= ld_ss_d;
         ld_cs_q <= ld_cs_d;
         load_q  <= load_d;
         err_q   <= err_d;
      end
   end

   assign Run_en    = Run_en_in & (state_q == IDLE);
   assign Load      = load_q;
   assign Err       = err_q;
   assign Ld_hh     = ld_hh_q;
   assign Ld_mm     = ld_mm_q;
   assign Ld_ss     = ld_ss_q;
   assign Ld_cs     = ld_cs_q;
   assign Editing   = editing;
   assign Field_sel = field_sel;

`ifdef RTC_BLINK_EN
   localparam int BLINK_W = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;

   logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
   logic               blink_ph_q, blink_ph_d;

   // Blink timebase runs only while editing and restarts from zero on each edit.
   always_comb begin
      blink_cnt_d = '0;
      blink_ph_d  = 1'b0;
      if (editing) begin
         blink_ph_d = blink_ph_q;
         if (blink_cnt_q == BLINK_W'(BLINK_DIV - 1)) begin
            blink_ph_d = ~blink_ph_q;
         end else begin
            blink_cnt_d = blink_cnt_q + BLINK_W'(1);
         end
      end
   end

   // Blink timebase registers.
   always_ff @(posedge Clk or negedge Clrn) begin
      if (!Clrn) begin
         blink_cnt_q <= '0;
         blink_ph_q  <= 1'b0;
      end else begin
         blink_cnt_q <= blink_cnt_d;
         blink_ph_q  <= blink_ph_d;
      end
   end

   // Only the field being edited blinks; bit3 is HH, bit0 is CS.
   always_comb begin
      Blink_mask = 4'b0000;
      if (editing && blink_ph_q) begin
         case (field_sel)
            2'd0:    Blink_mask = 4'b1000;
            2'd1:    Blink_mask = 4'b0100;
            2'd2:    Blink_mask = 4'b0010;
            default: Blink_mask = 4'b0001;
         endcase
      end
   end
`else
   // Without the blink feature BLINK_DIV only needs to be sane.
   if (BLINK_DIV < 1) begin : g_blink_div_invalid
   end
`endif

endmodule

// File: tb/tb_rtc_preset_sequencer.sv
// tb/tb_rtc_preset_sequencer.sv - self-checking bench for rtc_preset_sequencer
module tb_rtc_preset_sequencer;

   localparam int DEB = 4;

   logic       Clk = 1'b0;
   logic       Clrn;
   logic       Key_set_n;
   logic       Key_next_n;
   logic [7:0] Sw_bcd;
   logic       Run_en_in;
   logic       Run_en;
   logic       Load;
   logic [4:0] Ld_hh;
   logic [5:0] Ld_mm;
   logic [5:0] Ld_ss;
   logic [6:0] Ld_cs;
   logic       Editing;
   logic [1:0] Field_sel;
   logic       Err;
`ifdef RTC_BLINK_EN
   logic [3:0] Blink_mask;
`endif

   int pass_cnt = 0;
   int chk_cnt  = 0;
   int load_cnt = 0;
   int err_cnt  = 0;
   int run_viol = 0;
   logic [23:0] exp_q[$];

   rtc_preset_sequencer #(.DEB_CYCLES(DEB), .DEB_W(3), .BLINK_DIV(8)) dut (
      .Clk        (Clk),
      .Clrn       (Clrn),
      .Key_set_n  (Key_set_n),
      .Key_next_n (Key_next_n),
      .Sw_bcd     (Sw_bcd),
      .Run_en_in  (Run_en_in),
      .Run_en     (Run_en),
      .Load       (Load),
      .Ld_hh      (Ld_hh),
      .Ld_mm      (Ld_mm),
      .Ld_ss      (Ld_ss),
      .Ld_cs      (Ld_cs),
      .Editing    (Editing),
      .Field_sel  (Field_sel),
      .Err        (Err)
`ifdef RTC_BLINK_EN
      ,
      .Blink_mask (Blink_mask)
`endif
   );

   always #5 Clk = ~Clk;

   // Scoreboard consumer: every Load pulse pops one expected preset.
   always @(negedge Clk) begin
      logic [23:0] e;
      if (Clrn) begin
         if (Err) err_cnt++;
         if (Editing && Run_en) run_viol++;
         if (Load) begin
            load_cnt++;
            chk_cnt++;
            if (exp_q.size() == 0) begin
               $display("FAIL unexpected_load: got hh=%0d mm=%0d ss=%0d cs=%0d, none expected", Ld_hh, Ld_mm, Ld_ss, Ld_cs);
            end else begin
               e = exp_q.pop_front();
               if ({Ld_hh, Ld_mm, Ld_ss, Ld_cs} !== e)
                  $display("FAIL load_values: got hh=%0d mm=%0d ss=%0d cs=%0d, want hh=%0d mm=%0d ss=%0d cs=%0d",
                           Ld_hh, Ld_mm, Ld_ss, Ld_cs, e[23:19], e[18:13], e[12:7], e[6:0]);
               else
                  pass_cnt++;
            end
         end
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge Clk);
      #1;
   endtask

   task automatic press(input logic s, input logic n);
      Key_set_n  = ~s;
      Key_next_n = ~n;
      cyc(DEB + 2);
      Key_set_n  = 1'b1;
      Key_next_n = 1'b1;
      cyc(DEB + 4);
   endtask

   task automatic test_reset;
      chk_cnt++; if (Editing !== 1'b0)   $display("FAIL rst_editing: got %0b want 0", Editing);     else pass_cnt++;
      chk_cnt++; if (Field_sel !== 2'd0) $display("FAIL rst_field: got %0d want 0", Field_sel);     else pass_cnt++;
      chk_cnt++; if ({Load, Err} !== 2'b00) $display("FAIL rst_pulses: got %b want 00", {Load, Err}); else pass_cnt++;
      chk_cnt++; if ({Ld_hh, Ld_mm, Ld_ss, Ld_cs} !== 24'd0) $display("FAIL rst_ld: got %h want 0", {Ld_hh, Ld_mm, Ld_ss, Ld_cs}); else pass_cnt++;
      chk_cnt++; if (Run_en !== 1'b1)    $display("FAIL rst_run_en: got %0b want 1", Run_en);       else pass_cnt++;
   endtask

   task automatic test_full_set;
      logic [7:0] sw [4];
      int l0;
      sw[0] = 8'h12; sw[1] = 8'h34; sw[2] = 8'h56; sw[3] = 8'h78;
      l0 = load_cnt;
      press(1'b1, 1'b0);
      chk_cnt++; if ({Editing, Field_sel} !== 3'b100) $display("FAIL full_enter: got %b want 100", {Editing, Field_sel}); else pass_cnt++;
      chk_cnt++; if (Run_en !== 1'b0) $display("FAIL full_run_frozen: got %0b want 0", Run_en); else pass_cnt++;
      for (int i = 0; i < 4; i++) begin
         Sw_bcd = sw[i];
         if (i == 3) exp_q.push_back({5'd12, 6'd34, 6'd56, 7'd78});
         press(1'b0, 1'b1);
         chk_cnt++;
         if (Field_sel !== 2'((i + 1) % 4) || Editing !== (i < 3))
            $display("FAIL full_advance%0d: got edit=%0b field=%0d want edit=%0b field=%0d", i, Editing, Field_sel, (i < 3), (i + 1) % 4);
         else pass_cnt++;
      end
      chk_cnt++; if (load_cnt - l0 !== 1) $display("FAIL full_load_count: got %0d want 1", load_cnt - l0); else pass_cnt++;
      chk_cnt++; if (Run_en !== 1'b1) $display("FAIL full_run_resume: got %0b want 1", Run_en); else pass_cnt++;
      chk_cnt++; if ({Ld_hh, Ld_cs} !== {5'd12, 7'd78}) $display("FAIL full_ld_hold: got hh=%0d cs=%0d want 12 78", Ld_hh, Ld_cs); else pass_cnt++;
      chk_cnt++; if (run_viol !== 0) $display("FAIL full_run_during_edit: got %0d want 0", run_viol); else pass_cnt++;
   endtask

   task automatic test_clamp_err;
      int e0;
      press(1'b1, 1'b0);
      Sw_bcd = 8'h31; press(1'b0, 1'b1);
      chk_cnt++; if (Field_sel !== 2'd1) $display("FAIL clamp_hh_adv: got %0d want 1", Field_sel); else pass_cnt++;
      e0 = err_cnt;
      Sw_bcd = 8'h7A; press(1'b0, 1'b1);
      chk_cnt++; if (err_cnt - e0 !== 1) $display("FAIL err_units_pulse: got %0d want 1", err_cnt - e0); else pass_cnt++;
      chk_cnt++; if ({Editing, Field_sel} !== 3'b101) $display("FAIL err_stay_mm: got %b want 101", {Editing, Field_sel}); else pass_cnt++;
      Sw_bcd = 8'h99; press(1'b0, 1'b1);
      e0 = err_cnt;
      Sw_bcd = 8'hA5; press(1'b0, 1'b1);
      chk_cnt++; if (err_cnt - e0 !== 1 || Field_sel !== 2'd2) $display("FAIL err_tens: got errs=%0d field=%0d want 1 2", err_cnt - e0, Field_sel); else pass_cnt++;
      Sw_bcd = 8'h60; press(1'b0, 1'b1);
      exp_q.push_back({5'd23, 6'd59, 6'd59, 7'd99});
      Sw_bcd = 8'h99; press(1'b0, 1'b1);
      chk_cnt++; if (Editing !== 1'b0) $display("FAIL clamp_done: got %0b want 0", Editing); else pass_cnt++;
   endtask

   task automatic test_debounce;
      int l0, e0;
      l0 = load_cnt; e0 = err_cnt;
      for (int i = 0; i < 4; i++) begin
         Key_set_n = 1'b0; cyc(DEB - 1);
         Key_set_n = 1'b1; cyc(3);
      end
      cyc(DEB + 2);
      chk_cnt++; if (Editing !== 1'b0) $display("FAIL deb_bounce: got %0b want 0", Editing); else pass_cnt++;
      Key_set_n = 1'b0; cyc(5 * DEB);
      Key_set_n = 1'b1; cyc(DEB + 4);
      chk_cnt++; if (Editing !== 1'b1) $display("FAIL deb_single_pulse: got %0b want 1", Editing); else pass_cnt++;
      press(1'b1, 1'b0);
      chk_cnt++; if (Editing !== 1'b0) $display("FAIL deb_abort: got %0b want 0", Editing); else pass_cnt++;
      chk_cnt++; if (load_cnt - l0 !== 0 || err_cnt - e0 !== 0) $display("FAIL deb_side: got loads=%0d errs=%0d want 0 0", load_cnt - l0, err_cnt - e0); else pass_cnt++;
   endtask

   task automatic test_abort_simultaneous;
      int l0, e0;
      Run_en_in = 1'b0;
      press(1'b1, 1'b0);
      Sw_bcd = 8'h11; press(1'b0, 1'b1);
      Sw_bcd = 8'h22; press(1'b0, 1'b1);
      chk_cnt++; if (Field_sel !== 2'd2) $display("FAIL abort_in_ss: got %0d want 2", Field_sel); else pass_cnt++;
      l0 = load_cnt; e0 = err_cnt;
      Sw_bcd = 8'h33; press(1'b1, 1'b1);
      chk_cnt++; if ({Editing, Field_sel} !== 3'b000) $display("FAIL abort_idle: got %b want 000", {Editing, Field_sel}); else pass_cnt++;
      chk_cnt++; if (load_cnt - l0 !== 0 || err_cnt - e0 !== 0) $display("FAIL abort_side: got loads=%0d errs=%0d want 0 0", load_cnt - l0, err_cnt - e0); else pass_cnt++;
      chk_cnt++; if (Run_en !== 1'b0) $display("FAIL abort_run_off: got %0b want 0", Run_en); else pass_cnt++;
      Run_en_in = 1'b1; #1;
      chk_cnt++; if (Run_en !== 1'b1) $display("FAIL abort_run_on: got %0b want 1", Run_en); else pass_cnt++;
   endtask

   task automatic test_reset_mid_edit;
      press(1'b1, 1'b0);
      Sw_bcd = 8'h05; press(1'b0, 1'b1);
      chk_cnt++; if (Field_sel !== 2'd1) $display("FAIL rme_in_mm: got %0d want 1", Field_sel); else pass_cnt++;
      @(posedge Clk); #3;
      Clrn = 1'b0; #1;
      chk_cnt++; if ({Editing, Field_sel, Load, Err} !== 5'b0) $display("FAIL rme_async: got %b want 00000", {Editing, Field_sel, Load, Err}); else pass_cnt++;
      chk_cnt++; if ({Ld_hh, Ld_mm, Ld_ss, Ld_cs} !== 24'd0) $display("FAIL rme_ld_clear: got %h want 0", {Ld_hh, Ld_mm, Ld_ss, Ld_cs}); else pass_cnt++;
      cyc(2); Clrn = 1'b1; cyc(2);
      press(1'b1, 1'b0);
      chk_cnt++; if ({Editing, Field_sel} !== 3'b100) $display("FAIL rme_restart_hh: got %b want 100", {Editing, Field_sel}); else pass_cnt++;
      press(1'b1, 1'b0);
   endtask

`ifdef RTC_BLINK_EN
   task automatic test_blink;
      logic [3:0] v [64];
      int first;
      press(1'b1, 1'b0);
      Sw_bcd = 8'h01; press(1'b0, 1'b1);
      press(1'b0, 1'b1);
      for (int k = 0; k < 64; k++) begin
         v[k] = Blink_mask;
         cyc(1);
      end
      first = -1;
      for (int k = 1; k < 40; k++)
         if (first < 0 && v[k] !== v[k - 1]) first = k;
      chk_cnt++; if (first < 0 || (v[first] | v[first - 1]) !== 4'b0010) $display("FAIL blink_values: first_change=%0d want mask pair 0010/0000", first); else pass_cnt++;
      if (first > 0) begin
         for (int k = 0; k < 24; k++) begin
            chk_cnt++;
            if (v[first + k] !== (((k / 8) % 2 == 0) ? v[first] : v[first - 1]))
               $display("FAIL blink_period: offset %0d got %b", k, v[first + k]);
            else pass_cnt++;
         end
      end
      press(1'b1, 1'b0);
      chk_cnt++; if (Blink_mask !== 4'b0000) $display("FAIL blink_idle: got %b want 0000", Blink_mask); else pass_cnt++;
   endtask
`endif

   initial begin
      Clrn       = 1'b0;
      Key_set_n  = 1'b1;
      Key_next_n = 1'b1;
      Sw_bcd     = 8'h00;
      Run_en_in  = 1'b1;
      cyc(3);
      Clrn = 1'b1;
      cyc(2);
      test_reset;
      test_full_set;
      test_clamp_err;
      test_debounce;
      test_abort_simultaneous;
      test_reset_mid_edit;
`ifdef RTC_BLINK_EN
      test_blink;
`endif
      cyc(4);
      chk_cnt++; if (exp_q.size() !== 0) $display("FAIL missing_loads: got %0d pending want 0", exp_q.size()); else pass_cnt++;
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
